mult_accum: RTL and testbench



---
 rtl/mult_accum.sv | 124 ++++++++++++
 tb/tb_mult_accum.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mult_accum.sv
// Frame accumulator: sums frame_len unsigned products per frame and holds the result on a valid/ready port.
// Optional build macro MULT_ACCUM_SAT_EN: clamp the sum at 2^ACC_W-1 on overflow (default wraps).
module mult_accum #(
    parameter int PROD_W = 36,
    parameter int ACC_W  = 48,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] in_prod,
    output logic              in_ready,
    input  logic [LEN_W-1:0]  frame_len,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   len;
    logic               ovf;

    logic               beat;
    logic [LEN_W-1:0]   first_len;
    logic               last_beat;
    logic [ACC_W:0]     add_sum;
    logic [ACC_W-1:0]   acc_nxt;
    logic               ovf_nxt;

`ifdef MULT_ACCUM_SAT_EN
    // Once the frame has overflowed the accumulator stays pinned at full scale.
    function automatic logic [ACC_W-1:0] sat_clamp(input logic [ACC_W:0] s, input logic sticky);
        return (s[ACC_W] || sticky) ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    assign acc_nxt = sat_clamp(add_sum, ovf);
`else
    assign acc_nxt = add_sum[ACC_W-1:0];
`endif

    assign beat      = in_valid && in_ready;
    assign first_len = (frame_len == '0) ? LEN_W'(1) : frame_len;
    assign last_beat = ({1'b0, cnt} + (LEN_W+1)'(1)) == {1'b0, len};
    assign add_sum   = {1'b0, acc} + (ACC_W+1)'(in_prod);
    assign ovf_nxt   = ovf | add_sum[ACC_W];
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = (first_len == LEN_W'(1)) ? HOLD : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_beat)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (beat) begin
                        acc <= ACC_W'(in_prod);
                        cnt <= LEN_W'(1);
                        len <= first_len;
                        ovf <= 1'b0;
                        if (first_len == LEN_W'(1)) begin
                            out_valid <= 1'b1;
                            out_sum   <= ACC_W'(in_prod);
                            out_ovf   <= 1'b0;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc <= acc_nxt;
                        cnt <= cnt + LEN_W'(1);
                        ovf <= ovf_nxt;
                        // Result register is loaded on the final beat so it is valid one cycle later.
                        if (last_beat) begin
                            out_valid <= 1'b1;
                            out_sum   <= acc_nxt;
                            out_ovf   <= ovf_nxt;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready)
                        out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_accum.sv
// Directed plus randomized bench for mult_accum; frame sums checked against a plain-arithmetic reference.
module tb_mult_accum;
    localparam int PROD_W = 36;
    localparam int ACC_W  = 38;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [PROD_W-1:0] in_prod = '0;
    logic              in_ready;
    logic [LEN_W-1:0]  frame_len = '0;
    logic              out_valid;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic              out_ready = 1'b0;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;
    longint unsigned prod_q[$];

    mult_accum #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_prod(in_prod),
        .in_ready(in_ready), .frame_len(frame_len), .out_valid(out_valid),
        .out_sum(out_sum), .out_ovf(out_ovf), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives every product in prod_q as one frame, then checks the held result and its release.
    task automatic run_frame(input logic [LEN_W-1:0] fl, input logic [LEN_W-1:0] fl_later,
                             input int gap_lo, input int gap_hi, input int hold_cycles);
        longint unsigned total;
        longint unsigned lim;
        longint unsigned exp_sum;
        logic            exp_ovf;
        int              n;
        n = prod_q.size();
        total = 0;
        foreach (prod_q[i]) total += prod_q[i];
        lim = 64'd1 << ACC_W;
        exp_ovf = (total >= lim);
`ifdef MULT_ACCUM_SAT_EN
        exp_sum = exp_ovf ? lim - 1 : total;
`else
        exp_sum = total % lim;
`endif
        for (int i = 0; i < n; i++) begin
            if (i > 0 && gap_hi > 0) begin
                int g;
                g = $urandom_range(gap_hi, gap_lo);
                repeat (g) begin
                    step();
                    chk("gap_out_valid", out_valid, 0);
                    chk("gap_busy", busy, 1);
                end
            end
            in_valid  = 1'b1;
            in_prod   = prod_q[i][PROD_W-1:0];
            frame_len = (i == 0) ? fl : fl_later;
            chk("beat_in_ready", in_ready, 1);
            chk("early_out_valid", out_valid, 0);
            step();
            in_valid = 1'b0;
            in_prod  = '0;
        end
        chk("latency_out_valid", out_valid, 1);
        chk("out_sum", out_sum, exp_sum);
        chk("out_ovf", out_ovf, exp_ovf);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_busy", busy, 1);
        repeat (hold_cycles) begin
            step();
            chk("hold_out_valid", out_valid, 1);
            chk("hold_sum_stable", out_sum, exp_sum);
            chk("hold_ovf_stable", out_ovf, exp_ovf);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release_out_valid", out_valid, 0);
        chk("release_busy", busy, 0);
        chk("release_in_ready", in_ready, 1);
        prod_q.delete();
    endtask

    initial begin
        longint unsigned p;
        int              n;
        logic [LEN_W-1:0] fl;

        rst_n = 1'b0;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();

        prod_q = '{100, 200, 300, 400};
        run_frame(8'd4, 8'd4, 0, 0, 0);

        prod_q = '{7};
        run_frame(8'd0, 8'd0, 0, 0, 0);
        prod_q = '{9};
        run_frame(8'd0, 8'd0, 0, 0, 0);

        prod_q = '{5, 6, 7};
        run_frame(8'd3, 8'd3, 2, 2, 3);

        for (int i = 0; i < 5; i++) prod_q.push_back(64'd68719476735);
        run_frame(8'd5, 8'd5, 0, 0, 1);

        // Abort a frame part-way; a beat presented during reset must be dropped.
        in_valid  = 1'b1;
        frame_len = 8'd4;
        in_prod   = 36'd10;
        step();
        in_prod   = 36'd20;
        step();
        rst_n     = 1'b0;
        in_prod   = 36'd999;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_sum", out_sum, 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_prod  = '0;
        step();
        chk("after_abort_out_valid", out_valid, 0);
        prod_q = '{1, 2, 3, 4};
        run_frame(8'd4, 8'd4, 0, 0, 0);

        prod_q = '{1, 1, 1, 1};
        run_frame(8'd4, 8'd2, 0, 0, 0);

        repeat (25) begin
            n  = $urandom_range(6, 1);
            fl = LEN_W'(n);
            if (n == 1 && $urandom_range(1, 0) == 1) fl = '0;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(1, 0) == 1)
                    p = (64'd1 << PROD_W) - 1 - 64'($urandom_range(1000, 0));
                else
                    p = (64'($urandom_range(15, 0)) << 32) | 64'($urandom);
                prod_q.push_back(p);
            end
            run_frame(fl, LEN_W'($urandom), 0, 2, $urandom_range(2, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
